// File: rtl/seg_capture.sv
// Sniffs a multiplexed 4-digit, active-low 7-segment display and emits one decoded
// record per stably-held digit, keeping a frame of the last good value per digit.
`timescale 1ns/1ps
module seg_capture #(
   parameter int STABLE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  dig_sel,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_digit,
   output logic [3:0]  out_val,
   output logic        out_blank,
   output logic        out_err,
   output logic [15:0] frame_out,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, QUAL, EMIT, WAIT_CHG} state_t;

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   // Returns {err, blank, val}; blank and err are mutually exclusive by construction.
   function automatic logic [5:0] decode_seg(input logic [6:0] seg);
      logic [5:0] r;
      case (seg)
         7'b1000000: r = {2'b00, 4'h0};
         7'b1111001: r = {2'b00, 4'h1};
         7'b0100100: r = {2'b00, 4'h2};
         7'b0110000: r = {2'b00, 4'h3};
         7'b0011001: r = {2'b00, 4'h4};
         7'b0010010: r = {2'b00, 4'h5};
         7'b0000010: r = {2'b00, 4'h6};
         7'b1111000: r = {2'b00, 4'h7};
         7'b0000000: r = {2'b00, 4'h8};
         7'b0011000: r = {2'b00, 4'h9};
         7'b0001000: r = {2'b00, 4'hA};
         7'b0000011: r = {2'b00, 4'hB};
         7'b0100111: r = {2'b00, 4'hC};
         7'b0100001: r = {2'b00, 4'hD};
         7'b0000110: r = {2'b00, 4'hE};
         7'b0001110: r = {2'b00, 4'hF};
         7'b1111111: r = {2'b01, 4'h0};
         default:    r = {2'b10, 4'h0};
      endcase
      return r;
   endfunction

   function automatic logic sel_valid(input logic [3:0] sel);
      return (sel == 4'b1110) || (sel == 4'b1101) || (sel == 4'b1011) || (sel == 4'b0111);
   endfunction

   function automatic logic [1:0] sel_index(input logic [3:0] sel);
      logic [1:0] r;
      case (sel)
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         4'b0111: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   // Reset asserts immediately but releases only on a clock edge.
   logic rst_meta_q, rst_sync_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   logic [6:0] seg_s1_q, seg_s2_q;
   logic [3:0] sel_s1_q, sel_s2_q;
   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         seg_s1_q <= '1;
         seg_s2_q <= '1;
         sel_s1_q <= '1;
         sel_s2_q <= '1;
      end else begin
         seg_s1_q <= seg_in;
         seg_s2_q <= seg_s1_q;
         sel_s1_q <= dig_sel;
         sel_s2_q <= sel_s1_q;
      end
   end

   state_t      state_q, state_d;
   logic [6:0]  cap_seg_q, cap_seg_d;
   logic [3:0]  cap_sel_q, cap_sel_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  out_digit_q, out_digit_d;
   logic [3:0]  out_val_q, out_val_d;
   logic        out_blank_q, out_blank_d;
   logic        out_err_q, out_err_d;
   logic [15:0] frame_q, frame_d;
   logic        overrun_q, overrun_d;
   logic [5:0]  cap_dec;
   logic [1:0]  cap_idx;
   logic        pair_eq;

   assign cap_dec = decode_seg(cap_seg_q);
   assign cap_idx = sel_index(cap_sel_q);
   assign pair_eq = (seg_s2_q == cap_seg_q) && (sel_s2_q == cap_sel_q);

   always_comb begin
      state_d     = state_q;
      cap_seg_d   = cap_seg_q;
      cap_sel_d   = cap_sel_q;
      cnt_d       = cnt_q;
      out_digit_d = out_digit_q;
      out_val_d   = out_val_q;
      out_blank_d = out_blank_q;
      out_err_d   = out_err_q;
      frame_d     = frame_q;
      overrun_d   = overrun_q;
      case (state_q)
         IDLE: begin
            if (sel_valid(sel_s2_q)) begin
               cap_seg_d = seg_s2_q;
               cap_sel_d = sel_s2_q;
               cnt_d     = '0;
               state_d   = QUAL;
            end
         end
         QUAL: begin
            if (!pair_eq) begin
               cap_seg_d = seg_s2_q;
               cap_sel_d = sel_s2_q;
               cnt_d     = '0;
               if (!sel_valid(sel_s2_q)) state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               // Record and frame are both taken from the qualified capture.
               state_d     = EMIT;
               out_digit_d = cap_idx;
               out_val_d   = cap_dec[3:0];
               out_blank_d = cap_dec[4];
               out_err_d   = cap_dec[5];
               if (!cap_dec[5]) frame_d[{cap_idx, 2'b00} +: 4] = cap_dec[3:0];
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         EMIT: begin
            if (sel_valid(sel_s2_q) && (sel_s2_q != cap_sel_q)) overrun_d = 1'b1;
            if (out_ready) state_d = WAIT_CHG;
         end
         WAIT_CHG: begin
            if (sel_s2_q != cap_sel_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         state_q     <= IDLE;
         cap_seg_q   <= '1;
         cap_sel_q   <= '1;
         cnt_q       <= '0;
         out_digit_q <= '0;
         out_val_q   <= '0;
         out_blank_q <= 1'b0;
         out_err_q   <= 1'b0;
         frame_q     <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cap_seg_q   <= cap_seg_d;
         cap_sel_q   <= cap_sel_d;
         cnt_q       <= cnt_d;
         out_digit_q <= out_digit_d;
         out_val_q   <= out_val_d;
         out_blank_q <= out_blank_d;
         out_err_q   <= out_err_d;
         frame_q     <= frame_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = (state_q == EMIT);
   assign out_digit = out_digit_q;
   assign out_val   = out_val_q;
   assign out_blank = out_blank_q;
   assign out_err   = out_err_q;
   assign frame_out = frame_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: run-length reference model checked every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
`timescale 1ns/1ps
module tb_seg_capture;

   localparam int S = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  seg_in = 7'h7F;
   logic [3:0]  dig_sel = 4'hF;
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [1:0]  out_digit;
   logic [3:0]  out_val;
   logic        out_blank;
   logic        out_err;
   logic [15:0] frame_out;
   logic        overrun;

   always #5 clk = ~clk;

   seg_capture #(.STABLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
      .out_val(out_val), .out_blank(out_blank), .out_err(out_err),
      .frame_out(frame_out), .overrun(overrun)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Digit glyphs in value order 0..F.
   logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                            7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};

   function automatic logic [5:0] ref_decode(input logic [6:0] p);
      if (p == 7'h7F) return 6'b01_0000;
      for (int i = 0; i < 16; i++)
         if (tbl[i] == p) return {2'b00, 4'(i)};
      return 6'b10_0000;
   endfunction

   function automatic int one_low(input logic [3:0] s);
      int zeros, idx;
      zeros = 0;
      idx = -1;
      for (int i = 0; i < 4; i++)
         if (!s[i]) begin zeros++; idx = i; end
      return (zeros == 1) ? idx : -1;
   endfunction

   // Model: a record is produced once the synchronized {seg,sel} pair has been seen
   // valid and unchanged on S+1 consecutive edges while no record is outstanding and
   // the previous digit's select has since changed.
   logic [10:0] h1, h2, run_pair;
   int          run, rst_cnt;
   bit          pending, waiting, m_ov;
   logic [3:0]  rec_sel;
   logic [1:0]  rec_digit;
   logic [3:0]  rec_val;
   bit          rec_blank, rec_err;
   logic [15:0] m_frame;

   initial begin
      logic [10:0] p;
      logic [5:0]  d;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            h1 = '1; h2 = '1; run = 0; pending = 0; waiting = 0;
            m_frame = '0; m_ov = 0; rst_cnt = 2;
         end else if (rst_cnt > 0) begin
            rst_cnt--;
         end else begin
            p  = h2;
            h2 = h1;
            h1 = {seg_in, dig_sel};
            if (pending) begin
               if (one_low(p[3:0]) >= 0 && p[3:0] != rec_sel) m_ov = 1;
               if (out_ready) begin pending = 0; waiting = 1; end
            end else if (waiting) begin
               if (p[3:0] != rec_sel) waiting = 0;
            end else begin
               if (one_low(p[3:0]) < 0) run = 0;
               else if (run > 0 && p == run_pair) run++;
               else begin run = 1; run_pair = p; end
               if (run == S + 1) begin
                  d         = ref_decode(run_pair[10:4]);
                  pending   = 1;
                  rec_sel   = run_pair[3:0];
                  rec_digit = 2'(one_low(run_pair[3:0]));
                  rec_val   = d[3:0];
                  rec_blank = d[4];
                  rec_err   = d[5];
                  if (!rec_err) m_frame[rec_digit*4 +: 4] = rec_val;
                  run = 0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #2;
         chk("m_valid", out_valid, pending);
         if (pending) begin
            chk("m_digit", out_digit, rec_digit);
            chk("m_val",   out_val,   rec_val);
            chk("m_blank", out_blank, rec_blank);
            chk("m_err",   out_err,   rec_err);
         end
         chk("m_frame",   frame_out, m_frame);
         chk("m_overrun", overrun,   m_ov);
      end
   end

   task automatic drive(input logic [6:0] s, input logic [3:0] d);
      @(negedge clk);
      seg_in  = s;
      dig_sel = d;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      dig_sel = 4'hF;
      repeat (n) @(negedge clk);
   endtask

   // Edge count (from the edge after the drive) at which out_valid is seen; -1 on timeout.
   task automatic wait_valid(input int maxc, output int edges);
      edges = 0;
      while (edges < maxc) begin
         @(posedge clk);
         edges++;
         #1;
         if (out_valid) return;
      end
      edges = -1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, nv, n0, n2, hold, r;
      logic [3:0] cur_sel;
      logic [6:0] cur_seg;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_digit", out_digit, 0);
      chk("rst_val",   out_val,   0);
      chk("rst_blank", out_blank, 0);
      chk("rst_err",   out_err,   0);
      chk("rst_frame", frame_out, 16'h0000);
      chk("rst_ovr",   overrun,   0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // Digit 1 shows "2": first record after edge S+3
      drive(7'b0100100, 4'b1101);
      wait_valid(40, e);
      chk("lat_edge", e, S + 3);
      chk("d1_digit", out_digit, 1);
      chk("d1_val",   out_val,   2);
      chk("d1_frame", frame_out, 16'h0020);
      @(posedge clk);
      #1;
      chk("d1_pulse", out_valid, 0);
      idle(6);

      // Glyph toggling faster than qualification never produces a record
      nv = 0;
      @(negedge clk);
      dig_sel = 4'b1110;
      for (int t = 0; t < 6; t++) begin
         seg_in = t[0] ? 7'b1111000 : 7'b0000000;
         repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) nv++;
         end
         @(negedge clk);
      end
      chk("toggle_none", nv, 0);
      seg_in = 7'b0000000;
      wait_valid(40, e);
      chk("p8_seen",  e > 0, 1);
      chk("p8_val",   out_val,   8);
      chk("p8_digit", out_digit, 0);
      chk("p8_frame", frame_out, 16'h0028);
      idle(6);

      // Digit 3: value, then blank clears nibble, then error leaves it alone
      drive(7'b0010010, 4'b0111);
      wait_valid(40, e);
      chk("d3_frame5", frame_out, 16'h5028);
      idle(6);
      drive(7'b1111111, 4'b0111);
      wait_valid(40, e);
      chk("blank_flag", out_blank, 1);
      chk("blank_err",  out_err,   0);
      chk("blank_val",  out_val,   0);
      chk("blank_nib",  frame_out[15:12], 0);
      idle(6);
      drive(7'b1010101, 4'b0111);
      wait_valid(40, e);
      chk("err_flag",  out_err,   1);
      chk("err_blank", out_blank, 0);
      chk("err_val",   out_val,   0);
      chk("err_frame", frame_out, 16'h0028);
      idle(6);

      // Back-pressure: select moves while record pending
      out_ready = 1'b0;
      drive(7'b1000000, 4'b1110);
      wait_valid(40, e);
      chk("bp_seen", e > 0, 1);
      drive(7'b1000000, 4'b1011);
      repeat (10) @(negedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_digit", out_digit, 0);
      chk("bp_val",   out_val,   0);
      chk("bp_ovr",   overrun,   1);
      @(negedge clk);
      out_ready = 1'b1;
      n0 = 0;
      n2 = 0;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (out_valid && out_ready && out_digit == 2'd0) n0++;
         if (out_valid && out_ready && out_digit == 2'd2) n2++;
         @(negedge clk);
      end
      chk("bp_once_d0", n0, 1);
      chk("bp_once_d2", n2, 1);
      idle(6);

      // Two selects low at once never qualifies; reset mid-record clears everything
      drive(7'b0011001, 4'b1100);
      nv = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) nv++;
      end
      chk("multi_none", nv, 0);
      out_ready = 1'b0;
      drive(7'b0011001, 4'b1101);
      wait_valid(40, e);
      chk("pre_rst_frame", frame_out, 16'h0040);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_frame", frame_out, 16'h0000);
      chk("mid_rst_ovr",   overrun,   0);
      @(negedge clk);
      @(negedge clk);
      #3;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      out_ready = 1'b1;
      idle(8);

      // Randomized phase, checked by the model
      cur_sel = 4'hF;
      cur_seg = 7'h7F;
      for (int k = 0; k < 150; k++) begin
         r = $urandom_range(0, 7);
         if (r <= 4)      cur_sel = ~(4'b0001 << $urandom_range(0, 3));
         else if (r == 5) cur_sel = 4'hF;
         else if (r == 6) cur_sel = ~((4'b0001 << $urandom_range(0, 3)) | 4'b1000);
         r = $urandom_range(0, 9);
         if (r <= 5)      cur_seg = tbl[$urandom_range(0, 15)];
         else if (r == 6) cur_seg = 7'h7F;
         else             cur_seg = 7'($urandom);
         hold = $urandom_range(1, 40);
         @(negedge clk);
         seg_in  = cur_seg;
         dig_sel = cur_sel;
         for (int c = 0; c < hold; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
         end
      end
      out_ready = 1'b1;
      idle(30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 16, meaning consecutive identical synchronized samples required to qualify a digit (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port seg_in, input, 7, sniffed active-low segment lines, bit order g,f,e,d,c,b,a (bit6..bit0), 0 = segment lit.
REQ-005 SHALL have port dig_sel, input, 4, active-low digit enables of a multiplexed 4-digit display, asynchronous to clk.
REQ-006 SHALL have port out_valid, output, 1, decoded-digit record available.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts the record.
REQ-008 SHALL have port out_digit, output, 2, index of the qualified digit (dig_sel bit position).
REQ-009 SHALL have port out_val, output, 4, decoded hex value.
REQ-010 SHALL have port out_blank, output, 1, pattern was all segments off.
REQ-011 SHALL have port out_err, output, 1, pattern not in decode table and not blank.
REQ-012 SHALL have port frame_out, output, 16, last good value per digit; digit n at bits [4n+3:4n].
REQ-013 SHALL have port overrun, output, 1, sticky flag: a digit was missed while a record was pending.

Function
REQ-014 SHALL pass seg_in and dig_sel through a 2-flop synchronizer; all further logic uses synchronized values only.
REQ-015 SHALL decode patterns (bit6..bit0): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110.
REQ-016 SHALL treat 1111111 as blank (out_val=0, out_blank=1) and every other undefined pattern as error (out_val=0, out_err=1); out_blank and out_err never both 1.
REQ-017 SHALL consider a synchronized dig_sel valid only when exactly one bit is 0; all-ones or multiple zeros is invalid.
REQ-018 SHALL implement FSM states IDLE, QUAL, EMIT, WAIT_CHG.
REQ-019 IDLE: on valid dig_sel, load captured pair {seg,dig_sel}, clear counter, go QUAL; otherwise stay.
REQ-020 QUAL: if synchronized pair differs from captured, reload captured, clear counter, stay (or go IDLE if dig_sel invalid); if equal and counter==STABLE_CYCLES-1, go EMIT; if equal otherwise, increment counter.
REQ-021 Latency: with pins held constant, out_valid SHALL rise after the (STABLE_CYCLES+3)th rising edge, counting the first edge sampling the new pin values as edge 1.
REQ-022 On entry to EMIT, out_digit/out_val/out_blank/out_err SHALL load from captured pair and remain stable while out_valid=1.
REQ-023 On entry to EMIT, frame_out nibble for out_digit SHALL update with out_val when out_err=0 (blank writes 0); err leaves it unchanged.
REQ-024 EMIT: out_valid=1; transfer occurs on an edge with out_valid&out_ready; then go WAIT_CHG; out_valid low the following cycle.
REQ-025 WAIT_CHG: stay while synchronized dig_sel equals captured dig_sel; on any change go IDLE (same digit never emitted twice without its select dropping).
REQ-026 While in EMIT, a synchronized dig_sel change to a valid select other than captured SHALL set overrun; overrun clears only on reset.
REQ-027 out_valid SHALL be 0 in IDLE, QUAL, WAIT_CHG.

Reset
REQ-028 On rst_n=0 SHALL immediately force: state IDLE, synchronizers to all-ones, counter 0, out_valid 0, out_digit 0, out_val 0, out_blank 0, out_err 0, frame_out 0x0000, overrun 0.
REQ-029 Reset mid-EMIT SHALL drop out_valid without a transfer; after release, qualification restarts from IDLE.
REQ-030 Reset release SHALL be synchronized so FSM leaves reset cleanly on a clk edge.

Verification
REQ-031 seg_in=0100100, dig_sel=1101 held, out_ready=1 -> out_valid pulses one cycle at edge 19 (STABLE_CYCLES=16), out_digit=1, out_val=2, frame_out=0x0020.
REQ-032 Pattern toggles 0000000/1111000 every 10 cycles on dig_sel=1110 -> out_valid never asserts; then held 0000000 -> out_val=8, out_digit=0.
REQ-033 seg_in=1111111 on digit 3 -> out_blank=1, out_val=0, frame_out[15:12]=0; seg_in=1010101 -> out_err=1, frame_out unchanged.
REQ-034 out_ready=0 with record pending, dig_sel moves 1110->1011 -> outputs held stable, overrun=1; after out_ready=1 one transfer only.
REQ-035 dig_sel=1100 held -> no record; rst_n pulsed low during EMIT -> out_valid=0, frame_out=0x0000 immediately, overrun=0.
